// File: rtl/upcnt_tmr_pkg.sv
// Shared definitions for the programmable up-counting timer.
package upcnt_tmr_pkg;

    localparam int unsigned UPCNT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tmr_state_e;

endpackage

// File: rtl/upcnt_tmr_upcnt.sv
// One-bit up-count slice: toggles on carry-in, loadable, ripples carry-out.
module upcnt (
    input  logic clk,
    input  logic resl,
    input  logic d,
    input  logic ld,
    input  logic ci,
    output logic q,
    output logic co
);

    logic r_q;

    always_ff @(posedge clk or negedge resl) begin
        if (!resl) begin
            r_q <= 1'b0;
        end else begin
            r_q <= ld ? d : (r_q ^ ci);
        end
    end

    assign q  = r_q;
    assign co = ci & r_q;

endmodule

// File: rtl/upcnt_tmr.sv
// Programmable up-counting timer: loadable counter, compare match with
// one-shot or auto-reload, cascadable carry-out and one-cycle match irq.
module upcnt_tmr
    import upcnt_tmr_pkg::*;
#(
    parameter int unsigned WIDTH = UPCNT_WIDTH
) (
    input  logic             clk,
    input  logic             resl,
    input  logic [WIDTH-1:0] d,
    input  logic             ld,
    input  logic             ci,
    input  logic [WIDTH-1:0] cmp_d,
    input  logic             cmp_ld,
    input  logic             reload,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             busy,
    output logic             irq
);

    tmr_state_e       r_state;
    tmr_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_cmp;
    logic             r_irq;

    logic             w_run;
    logic             w_match;
    logic             w_slice_ld;
    logic [WIDTH-1:0] w_slice_d;
    logic [WIDTH:0]   w_carry;

    assign w_run   = (r_state == ST_RUN);
    assign w_match = w_run & ci & ~ld & (q == r_cmp);

    // Auto-reload zeroing rides on the slice load path; an explicit ld wins.
    assign w_slice_ld = ld | (w_match & reload);
    assign w_slice_d  = ld ? d : '0;
    assign w_carry[0] = w_run & ci & ~w_match;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slice
        upcnt u_slice (
            .clk  (clk),
            .resl (resl),
            .d    (w_slice_d[gi]),
            .ld   (w_slice_ld),
            .ci   (w_carry[gi]),
            .q    (q[gi]),
            .co   (w_carry[gi+1])
        );
    end

    // The chain is muted on a match, so restore carry-out for an all-ones match.
    assign co = w_carry[WIDTH] | (w_match & (&q));

    always_comb begin
        w_state_nxt = r_state;
        if (stop) begin
            w_state_nxt = ST_IDLE;
        end else if (start && (r_state != ST_RUN)) begin
            w_state_nxt = ST_RUN;
        end else if (w_match && !reload) begin
            w_state_nxt = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge resl) begin
        if (!resl) begin
            r_state <= ST_IDLE;
            r_cmp   <= '1;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_irq   <= w_match;
            if (cmp_ld) begin
                r_cmp <= cmp_d;
            end
        end
    end

    assign busy = w_run;
    assign irq  = r_irq;

endmodule

// File: tb/tb_upcnt_tmr.sv
// Self-checking bench for upcnt_tmr: per-cycle model comparison plus directed literals.
module tb_upcnt_tmr;

    localparam int W = 16;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic         clk = 1'b0;
    logic         resl = 1'b0;
    logic [W-1:0] d = '0;
    logic         ld = 1'b0;
    logic         ci = 1'b0;
    logic [W-1:0] cmp_d = '0;
    logic         cmp_ld = 1'b0;
    logic         reload = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [W-1:0] q;
    logic         co;
    logic         busy;
    logic         irq;

    int n_vec = 0;
    int n_err = 0;
    int irq_cnt = 0;

    int m_q = 0;
    int m_cmp = 65535;
    int m_st = M_IDLE;
    int m_irq = 0;

    upcnt_tmr #(.WIDTH(W)) dut (
        .clk    (clk),
        .resl   (resl),
        .d      (d),
        .ld     (ld),
        .ci     (ci),
        .cmp_d  (cmp_d),
        .cmp_ld (cmp_ld),
        .reload (reload),
        .start  (start),
        .stop   (stop),
        .q      (q),
        .co     (co),
        .busy   (busy),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Behavioural model of the timer rules, stepped on each clock edge.
    always @(posedge clk or negedge resl) begin
        if (!resl) begin
            m_q   = 0;
            m_cmp = 65535;
            m_st  = M_IDLE;
            m_irq = 0;
        end else begin
            int  nq;
            int  nst;
            bit  hit;
            hit = (m_st == M_RUN) && ci && !ld && (m_q == m_cmp);
            nq  = m_q;
            if (ld)
                nq = int'(d);
            else if (m_st == M_RUN && ci)
                nq = hit ? (reload ? 0 : m_q) : (m_q + 1) % 65536;
            nst = m_st;
            if (stop)
                nst = M_IDLE;
            else if (start && m_st != M_RUN)
                nst = M_RUN;
            else if (hit && !reload)
                nst = M_DONE;
            if (cmp_ld)
                m_cmp = int'(cmp_d);
            m_irq = hit ? 1 : 0;
            m_q   = nq;
            m_st  = nst;
        end
    end

    always @(negedge clk) begin
        check("q", 32'(q), 32'(m_q));
        check("busy", 32'(busy), 32'(m_st == M_RUN));
        check("irq", 32'(irq), 32'(m_irq));
        check("co", 32'(co), 32'(ci && m_st == M_RUN && m_q == 65535));
        if (irq === 1'b1)
            irq_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        ld     = 1'b0;
        cmp_ld = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
    endtask

    initial begin
        int exp_seq[12];
        exp_seq = '{1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3, 0};

        repeat (2) @(posedge clk);
        #1 resl = 1'b1;
        step();
        check("rst_q", 32'(q), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_co", 32'(co), 32'h0);

        // One-shot count to 5
        cmp_ld = 1'b1; cmp_d = 16'd5; reload = 1'b0; start = 1'b1;
        step();
        check("os_busy_start", 32'(busy), 32'h1);
        irq_cnt = 0;
        ci = 1'b1;
        repeat (10) step();
        ci = 1'b0;
        step();
        check("os_irq_count", 32'(irq_cnt), 32'd1);
        check("os_q_hold", 32'(q), 32'd5);
        check("os_busy_done", 32'(busy), 32'h0);

        // Auto-reload with cmp=3
        stop = 1'b1;
        step();
        ld = 1'b1; d = '0; cmp_ld = 1'b1; cmp_d = 16'd3; reload = 1'b1; start = 1'b1;
        step();
        irq_cnt = 0;
        ci = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            check("ar_q_seq", 32'(q), 32'(exp_seq[i]));
            check("ar_irq_slot", 32'(irq), 32'((i % 4) == 3));
        end
        ci = 1'b0;
        step();
        check("ar_irq_count", 32'(irq_cnt), 32'd3);

        // Wrap through all-ones with carry-out
        stop = 1'b1;
        step();
        ld = 1'b1; d = 16'hFFFE; cmp_ld = 1'b1; cmp_d = 16'h0001; reload = 1'b0; start = 1'b1;
        step();
        check("wr_q_load", 32'(q), 32'hFFFE);
        ci = 1'b1;
        #1 check("wr_co_fffe", 32'(co), 32'h0);
        step();
        check("wr_q_ffff", 32'(q), 32'hFFFF);
        check("wr_co_ffff", 32'(co), 32'h1);
        step();
        check("wr_q_0000", 32'(q), 32'h0000);
        check("wr_co_0000", 32'(co), 32'h0);
        check("wr_irq_0000", 32'(irq), 32'h0);
        step();
        check("wr_q_0001", 32'(q), 32'h0001);
        check("wr_irq_0001", 32'(irq), 32'h0);
        step();
        check("wr_irq_match", 32'(irq), 32'h1);
        check("wr_q_hold", 32'(q), 32'h0001);
        check("wr_busy_done", 32'(busy), 32'h0);
        ci = 1'b0;

        // Load overrides a match
        stop = 1'b1;
        step();
        ld = 1'b1; d = '0; cmp_ld = 1'b1; cmp_d = 16'd2; reload = 1'b1; start = 1'b1;
        step();
        ci = 1'b1;
        step();
        step();
        check("pr_q_at_cmp", 32'(q), 32'd2);
        ld = 1'b1; d = 16'h0010;
        step();
        check("pr_ld_q", 32'(q), 32'h0010);
        check("pr_ld_irq", 32'(irq), 32'h0);
        check("pr_ld_busy", 32'(busy), 32'h1);
        ci = 1'b0;

        // Start and stop together: stop wins
        start = 1'b1; stop = 1'b1;
        step();
        check("pr_stop_wins", 32'(busy), 32'h0);

        // Compare reload in the match cycle: old value matches
        ld = 1'b1; d = '0; cmp_ld = 1'b1; cmp_d = 16'd1; reload = 1'b0; start = 1'b1;
        step();
        ci = 1'b1;
        step();
        check("pr_q_one", 32'(q), 32'd1);
        cmp_ld = 1'b1; cmp_d = 16'd7;
        step();
        check("pr_oldcmp_irq", 32'(irq), 32'h1);
        check("pr_oldcmp_busy", 32'(busy), 32'h0);
        check("pr_oldcmp_q", 32'(q), 32'd1);
        ci = 1'b0;

        // Count-enable gating
        stop = 1'b1;
        step();
        ld = 1'b1; d = 16'h0020; start = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("gt_q_hold", 32'(q), 32'h0020);
            check("gt_irq", 32'(irq), 32'h0);
            check("gt_co", 32'(co), 32'h0);
            check("gt_busy", 32'(busy), 32'h1);
        end
        stop = 1'b1; ld = 1'b1; d = 16'hFFFF;
        step();
        ci = 1'b1;
        #1 check("gt_co_idle", 32'(co), 32'h0);
        check("gt_busy_idle", 32'(busy), 32'h0);
        step();
        check("gt_q_idle", 32'(q), 32'hFFFF);
        check("gt_co_idle2", 32'(co), 32'h0);
        ci = 1'b0;

        // Asynchronous reset mid-count at 0x42
        stop = 1'b1;
        step();
        ld = 1'b1; d = '0; cmp_ld = 1'b1; cmp_d = 16'h1000; reload = 1'b0; start = 1'b1;
        step();
        ci = 1'b1;
        repeat (16'h42) step();
        check("rs_q_42", 32'(q), 32'h42);
        #2 resl = 1'b0;
        #1;
        check("rs_q", 32'(q), 32'h0);
        check("rs_busy", 32'(busy), 32'h0);
        check("rs_irq", 32'(irq), 32'h0);
        check("rs_co", 32'(co), 32'h0);
        ci = 1'b0;
        @(posedge clk);
        #1 resl = 1'b1;

        // Compare register must be back at all-ones
        ld = 1'b1; d = 16'hFFFE; start = 1'b1;
        step();
        ci = 1'b1;
        step();
        check("rs_cmp_q", 32'(q), 32'hFFFF);
        check("rs_cmp_irq0", 32'(irq), 32'h0);
        step();
        check("rs_cmp_irq", 32'(irq), 32'h1);
        check("rs_cmp_hold", 32'(q), 32'hFFFF);
        check("rs_cmp_done", 32'(busy), 32'h0);
        ci = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/upcnt_tmr.md
Name: upcnt_tmr

Overview:
- Programmable up-counting timer; the count-up counterpart of the down-counter slices used in the object and blitter address logic.
- Loadable WIDTH-bit up-counter with terminal-compare register, one-shot / auto-reload modes, chained carry-out, one-cycle match interrupt pulse.
- Sits in the timer/interrupt area; irq feeds the interrupt controller; co cascades to a further upcnt_tmr for wider counts.

Parameters:
- WIDTH, 16, counter and compare register width in bits.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- resl  in  1  reset, asynchronous, active-low.
- d  in  WIDTH  counter load value.
- ld  in  1  load d into q this cycle.
- ci  in  1  count enable / carry-in from lower stage.
- cmp_d  in  WIDTH  compare register load value.
- cmp_ld  in  1  load cmp_d into compare register.
- reload  in  1  1 = auto-reload on match, 0 = one-shot.
- start  in  1  pulse: enter RUN.
- stop  in  1  pulse: enter IDLE.
- q  out  WIDTH  current count.
- co  out  1  carry-out = ci & running & (q == all-ones), combinational.
- busy  out  1  state == RUN.
- irq  out  1  registered one-cycle pulse on compare match.

Behaviour:
- Reset (resl low, async): q=0, cmp=all-ones, state=IDLE, irq=0; busy=0, co=0.
- States: IDLE (hold), RUN (count), DONE (one-shot expired, hold).
- IDLE/DONE -> RUN on start; any state -> IDLE on stop; start and stop same cycle: stop wins.
- RUN, ci=1, q==cmp: match. irq=1 next cycle. reload=1: q<=0, stay RUN. reload=0: q holds, -> DONE.
- RUN, ci=1, q!=cmp: q<=q+1 mod 2^WIDTH. all-ones wraps to 0, no irq.
- RUN, ci=0: q holds, no match evaluated.
- ld: highest priority on q in any state. q<=d; no match or increment that cycle; state transition still taken.
- cmp_ld: cmp<=cmp_d. Match in the same cycle uses the old cmp.
- irq: high exactly one cycle per match. Back-to-back matches give consecutive pulses (cmp=0 with reload).
- co: combinational, no register latency. Asserted only in RUN. Lower bound 0 on any reset.
- resl assertion mid-count: immediate return to reset values; pending irq dropped.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2), WIDTH default.
- Sub-module upcnt: 1-bit up-count slice.
  - Register q, async clear on resl.
  - Next value mux(ld ? d : q^ci).
  - co = ci & q.
- Instantiate WIDTH slices chained ci->co.
  - Chain ci = RUN & ci & !match.
  - Zeroing on auto-reload forced via the slice ld/d path.

Test Plan:
- Reset: assert resl low mid-RUN at q=0x0042 -> q=0, busy=0, irq=0, cmp=0xFFFF immediately, before the next clk edge.
- One-shot: cmp=5, reload=0, start, ci=1 -> q counts 0..5; irq pulses once the cycle after q=5; state DONE; q holds 5; busy=0.
- Auto-reload: cmp=3, reload=1, ci=1 for 12 cycles -> q sequence 0,1,2,3,0,1,2,3,0,...; three single-cycle irq pulses spaced 4 cycles apart.
- Wrap/carry: d=0xFFFE, ld, cmp=0x0001, start, ci=1 -> q=FFFE,FFFF,0000,0001. co=1 only while q=FFFF. irq after q=0001 only.
- Priority: ld with d=0x0010 in the match cycle -> q=0x0010, no irq. Start+stop same cycle -> IDLE. cmp_ld in the match cycle -> old cmp matches.
- Gating: ci=0 for 5 cycles in RUN -> q, irq, co unchanged. co=0 in IDLE even with q=FFFF and ci=1.
